// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between two word producers, the write arbiter and the
// FIFO write port. The master side is the arbiter; the slave side is the
// surrounding environment (producers plus FIFO).
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  req0_valid;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_ready;
  logic                  fifo_full;
  logic                  fifo_wr;
  logic [DATA_WIDTH-1:0] fifo_w_data;
  logic [1:0]            grant;

  modport master (
    input  req0_valid, req0_data, req1_valid, req1_data, fifo_full,
    output req0_ready, req1_ready, fifo_wr, fifo_w_data, grant
  );

  modport slave (
    output req0_valid, req0_data, req1_valid, req1_data, fifo_full,
    input  req0_ready, req1_ready, fifo_wr, fifo_w_data, grant
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: two valid/ready producers share one FIFO write
// port. A grant lasts up to MAX_BURST accepted words; accepted words go to
// the FIFO on the same edge they are accepted (write path is combinational).
// Optional per-producer accept counters are built when FIFO_ARB_STATS_EN is
// defined; without it the stat ports and counters do not exist.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  fifo_wr_arbiter_if.master     bus
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic                  stat_clr,
  output logic [STAT_WIDTH-1:0] stat_cnt0,
  output logic [STAT_WIDTH-1:0] stat_cnt1
`endif
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  // Reject configurations that cannot work at elaboration time.
  generate
    if (MAX_BURST < 1 || STAT_WIDTH < 1) begin : g_bad_param
      $error("fifo_wr_arbiter: MAX_BURST and STAT_WIDTH must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] burst_cnt_reg, burst_cnt_next;
  logic          last_reg, last_next;

  logic ready0, ready1;
  logic accept0, accept1;
  logic end0, end1;

  // Handshake and write-port outputs depend only on state and fifo_full/valid,
  // so a full FIFO stalls the granted producer without dropping its grant.
  always_comb begin
    ready0 = (state_reg == GNT0) && !bus.fifo_full;
    ready1 = (state_reg == GNT1) && !bus.fifo_full;
    accept0 = ready0 && bus.req0_valid;
    accept1 = ready1 && bus.req1_valid;
    // A grant ends on the last word of a burst or when its producer goes idle.
    end0 = (accept0 && (burst_cnt_reg == LAST_BEAT)) || !bus.req0_valid;
    end1 = (accept1 && (burst_cnt_reg == LAST_BEAT)) || !bus.req1_valid;
  end

  assign bus.req0_ready  = ready0;
  assign bus.req1_ready  = ready1;
  assign bus.fifo_wr     = accept0 || accept1;
  assign bus.grant       = {state_reg == GNT1, state_reg == GNT0};
  assign bus.fifo_w_data = (state_reg == GNT0) ? bus.req0_data :
                           (state_reg == GNT1) ? bus.req1_data :
                           '0;

  // Grant selection: ties from IDLE go to the producer not granted last;
  // at the end of a grant the other producer wins if waiting, otherwise the
  // same producer re-enters immediately so there is never a bubble cycle.
  always_comb begin
    state_next     = state_reg;
    burst_cnt_next = burst_cnt_reg;
    last_next      = last_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req0_valid && bus.req1_valid) begin
          state_next     = last_reg ? GNT0 : GNT1;
          burst_cnt_next = '0;
          last_next      = !last_reg;
        end else if (bus.req0_valid) begin
          state_next     = GNT0;
          burst_cnt_next = '0;
          last_next      = 1'b0;
        end else if (bus.req1_valid) begin
          state_next     = GNT1;
          burst_cnt_next = '0;
          last_next      = 1'b1;
        end
      end
      GNT0: begin
        if (accept0) begin
          burst_cnt_next = burst_cnt_reg + 1'b1;
        end
        if (end0) begin
          burst_cnt_next = '0;
          if (bus.req1_valid) begin
            state_next = GNT1;
            last_next  = 1'b1;
          end else if (bus.req0_valid) begin
            state_next = GNT0;
            last_next  = 1'b0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      GNT1: begin
        if (accept1) begin
          burst_cnt_next = burst_cnt_reg + 1'b1;
        end
        if (end1) begin
          burst_cnt_next = '0;
          if (bus.req0_valid) begin
            state_next = GNT0;
            last_next  = 1'b0;
          end else if (bus.req1_valid) begin
            state_next = GNT1;
            last_next  = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next     = IDLE;
        burst_cnt_next = '0;
      end
    endcase
  end

  // State registers; last resets to producer 1 so producer 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      burst_cnt_reg <= '0;
      last_reg      <= 1'b1;
    end else begin
      state_reg     <= state_next;
      burst_cnt_reg <= burst_cnt_next;
      last_reg      <= last_next;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] stat_cnt0_reg, stat_cnt1_reg;

  // Per-producer accept counters; a clear wins over a same-cycle accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_cnt0_reg <= '0;
      stat_cnt1_reg <= '0;
    end else if (stat_clr) begin
      stat_cnt0_reg <= '0;
      stat_cnt1_reg <= '0;
    end else begin
      if (accept0) stat_cnt0_reg <= stat_cnt0_reg + 1'b1;
      if (accept1) stat_cnt1_reg <= stat_cnt1_reg + 1'b1;
    end
  end

  assign stat_cnt0 = stat_cnt0_reg;
  assign stat_cnt1 = stat_cnt1_reg;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a table of per-cycle inputs and
// hand-computed outputs, followed by a continuous two-producer sequence that
// checks the round-robin order (and the stat counters when built in).
module tb_fifo_wr_arbiter;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  fifo_wr_arbiter_if #(.DATA_WIDTH(8)) bus ();

`ifdef FIFO_ARB_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_cnt0;
  logic [15:0] stat_cnt1;
`endif

  fifo_wr_arbiter #(
    .DATA_WIDTH(8),
    .MAX_BURST (4),
    .STAT_WIDTH(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_clr (stat_clr),
    .stat_cnt0(stat_cnt0),
    .stat_cnt1(stat_cnt1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       full;
    logic [1:0] g;
    logic       wr;
    logic [7:0] wd;
    logic       r0;
    logic       r1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic v0, input logic [7:0] d0,
                              input logic v1, input logic [7:0] d1, input logic full,
                              input logic [1:0] g, input logic wr, input logic [7:0] wd,
                              input logic r0, input logic r1);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.full = full;
    v.g = g; v.wr = wr; v.wd = wd; v.r0 = r0; v.r1 = r1;
    return v;
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {grant,wr,wdata,r0,r1}=%h want %h", name, act, exp);
    end else begin
      $display("ok   %s: {grant,wr,wdata,r0,r1}=%h", name, act);
    end
  endtask

  function automatic logic [12:0] outs();
    return {bus.grant, bus.fifo_wr, bus.fifo_w_data, bus.req0_ready, bus.req1_ready};
  endfunction

  initial begin
    logic [1:0] exp_g;
    logic [7:0] exp_wd;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_data = 8'h00;
    bus.req1_valid = 1'b0; bus.req1_data = 8'h00;
    bus.fifo_full  = 1'b0;
`ifdef FIFO_ARB_STATS_EN
    stat_clr = 1'b0;
`endif

    // Sole producer 0: six words 0x10..0x15, burst re-entry without a bubble.
    vecs.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 2'b00, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 8'h10, 0, 8'h00, 0, 2'b00, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 8'h10, 0, 8'h00, 0, 2'b01, 1, 8'h10, 1, 0));
    vecs.push_back(mk(0, 1, 8'h11, 0, 8'h00, 0, 2'b01, 1, 8'h11, 1, 0));
    vecs.push_back(mk(0, 1, 8'h12, 0, 8'h00, 0, 2'b01, 1, 8'h12, 1, 0));
    vecs.push_back(mk(0, 1, 8'h13, 0, 8'h00, 0, 2'b01, 1, 8'h13, 1, 0));
    vecs.push_back(mk(0, 1, 8'h14, 0, 8'h00, 0, 2'b01, 1, 8'h14, 1, 0));
    vecs.push_back(mk(0, 1, 8'h15, 0, 8'h00, 0, 2'b01, 1, 8'h15, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 2'b01, 0, 8'h00, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 2'b00, 0, 8'h00, 0, 0));
    // Both valid from reset: producer 0 wins the tie, bursts alternate with no gap.
    vecs.push_back(mk(1, 1, 8'h20, 1, 8'h30, 0, 2'b00, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 8'h20, 1, 8'h30, 0, 2'b00, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 8'h20, 1, 8'h30, 0, 2'b01, 1, 8'h20, 1, 0));
    vecs.push_back(mk(0, 1, 8'h21, 1, 8'h30, 0, 2'b01, 1, 8'h21, 1, 0));
    vecs.push_back(mk(0, 1, 8'h22, 1, 8'h30, 0, 2'b01, 1, 8'h22, 1, 0));
    vecs.push_back(mk(0, 1, 8'h23, 1, 8'h30, 0, 2'b01, 1, 8'h23, 1, 0));
    vecs.push_back(mk(0, 1, 8'h24, 1, 8'h30, 0, 2'b10, 1, 8'h30, 0, 1));
    vecs.push_back(mk(0, 1, 8'h24, 1, 8'h31, 0, 2'b10, 1, 8'h31, 0, 1));
    vecs.push_back(mk(0, 1, 8'h24, 1, 8'h32, 0, 2'b10, 1, 8'h32, 0, 1));
    vecs.push_back(mk(0, 1, 8'h24, 1, 8'h33, 0, 2'b10, 1, 8'h33, 0, 1));
    vecs.push_back(mk(0, 1, 8'h24, 1, 8'h34, 0, 2'b01, 1, 8'h24, 1, 0));
    // Reset mid-burst in GNT0 with producer 0 still valid: outputs drop at once.
    vecs.push_back(mk(1, 1, 8'h25, 1, 8'h40, 0, 2'b00, 0, 8'h00, 0, 0));
    // Producer 1 burst stalled three cycles by fifo_full after its second word.
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'h40, 0, 2'b00, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'h40, 0, 2'b10, 1, 8'h40, 0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'h41, 0, 2'b10, 1, 8'h41, 0, 1));
    vecs.push_back(mk(0, 1, 8'h50, 1, 8'h42, 1, 2'b10, 0, 8'h42, 0, 0));
    vecs.push_back(mk(0, 1, 8'h50, 1, 8'h42, 1, 2'b10, 0, 8'h42, 0, 0));
    vecs.push_back(mk(0, 1, 8'h50, 1, 8'h42, 1, 2'b10, 0, 8'h42, 0, 0));
    vecs.push_back(mk(0, 1, 8'h50, 1, 8'h42, 0, 2'b10, 1, 8'h42, 0, 1));
    vecs.push_back(mk(0, 1, 8'h50, 1, 8'h43, 0, 2'b10, 1, 8'h43, 0, 1));
    vecs.push_back(mk(0, 1, 8'h50, 0, 8'h00, 0, 2'b01, 1, 8'h50, 1, 0));
    // Producer 1 drops valid after two words; waiting producer 0 gets 4 words.
    vecs.push_back(mk(1, 0, 8'h00, 1, 8'h60, 0, 2'b00, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'h60, 0, 2'b00, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 8'h70, 1, 8'h60, 0, 2'b10, 1, 8'h60, 0, 1));
    vecs.push_back(mk(0, 1, 8'h70, 1, 8'h61, 0, 2'b10, 1, 8'h61, 0, 1));
    vecs.push_back(mk(0, 1, 8'h70, 0, 8'h00, 0, 2'b10, 0, 8'h00, 0, 1));
    vecs.push_back(mk(0, 1, 8'h70, 0, 8'h00, 0, 2'b01, 1, 8'h70, 1, 0));
    vecs.push_back(mk(0, 1, 8'h71, 0, 8'h00, 0, 2'b01, 1, 8'h71, 1, 0));
    vecs.push_back(mk(0, 1, 8'h72, 0, 8'h00, 0, 2'b01, 1, 8'h72, 1, 0));
    vecs.push_back(mk(0, 1, 8'h73, 0, 8'h00, 0, 2'b01, 1, 8'h73, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 2'b01, 0, 8'h00, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 2'b00, 0, 8'h00, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset          = vecs[i].rst;
      bus.req0_valid = vecs[i].v0;
      bus.req0_data  = vecs[i].d0;
      bus.req1_valid = vecs[i].v1;
      bus.req1_data  = vecs[i].d1;
      bus.fifo_full  = vecs[i].full;
      #1;
      check($sformatf("vec%0d", i), outs(),
            {vecs[i].g, vecs[i].wr, vecs[i].wd, vecs[i].r0, vecs[i].r1});
    end

    // Continuous contention from reset: 20 accepts in order 0000 1111 0000 ...
    @(negedge clk);
    reset = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_data = 8'hA0;
    bus.req1_valid = 1'b1; bus.req1_data = 8'hB0;
    bus.fifo_full  = 1'b0;
    #1;
    check("rr_reset", outs(), {2'b00, 1'b0, 8'h00, 1'b0, 1'b0});
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rr_idle", outs(), {2'b00, 1'b0, 8'h00, 1'b0, 1'b0});
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      exp_g  = ((k / 4) % 2 == 0) ? 2'b01 : 2'b10;
      exp_wd = ((k / 4) % 2 == 0) ? 8'hA0 : 8'hB0;
      check($sformatf("rr_word%0d", k), outs(),
            {exp_g, 1'b1, exp_wd, exp_g[0], exp_g[1]});
    end

`ifdef FIFO_ARB_STATS_EN
    @(negedge clk);
    #1;
    total++;
    if (stat_cnt0 !== 16'd12 || stat_cnt1 !== 16'd8) begin
      bad++;
      $display("FAIL stat_after20: got cnt0=%0d cnt1=%0d want 12 8", stat_cnt0, stat_cnt1);
    end else begin
      $display("ok   stat_after20: cnt0=%0d cnt1=%0d", stat_cnt0, stat_cnt1);
    end
    // Clear during an accepting cycle: the clear must win over the increment.
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    #1;
    total++;
    if (stat_cnt0 !== 16'd0 || stat_cnt1 !== 16'd0) begin
      bad++;
      $display("FAIL stat_clr: got cnt0=%0d cnt1=%0d want 0 0", stat_cnt0, stat_cnt1);
    end else begin
      $display("ok   stat_clr: cnt0=%0d cnt1=%0d", stat_cnt0, stat_cnt1);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
